// File: rtl/sched_pkg.sv
// Shared definitions for the fire scheduler: index widths, FSM states,
// LFSR feedback constants and the idle-code convention for the fire index.
package sched_pkg;

   // Width of an index that must also encode the idle value n.
   function automatic int idx_w(input int n);
      return $clog2(n + 1);
   endfunction

   // The fire index equal to the transition count selects nothing.
   function automatic int fire_idle(input int n);
      return n;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_FIRE,
      S_SETTLE,
      S_HOLD,
      S_DEAD
   } sched_state_t;

   // Right-shifting Galois feedback masks for maximal-length sequences.
   function automatic logic [63:0] lfsr_taps(input int w);
      case (w)
         8:       return 64'h0000_0000_0000_00B8;
         16:      return 64'h0000_0000_0000_B400;
         24:      return 64'h0000_0000_00E1_0000;
         32:      return 64'h0000_0000_8020_0003;
         default: return 64'h0000_0000_0000_B400;
      endcase
   endfunction

endpackage

// File: rtl/wrap_priority_pick.sv
// Finds the first set bit of a vector at or after a start index, wrapping
// around modulo N; also reports whether any bit is set at all.
module wrap_priority_pick #(
   parameter int N  = 8,
   parameter int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_vec,
   input  logic [SW-1:0] i_start,
   output logic [SW-1:0] o_idx,
   output logic          o_any
);

   logic [SW:0] w_pos;

   // Walking offsets from farthest to nearest lets the nearest hit win.
   always_comb begin
      o_idx = '0;
      o_any = |i_vec;
      w_pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = {1'b0, i_start} + (SW+1)'(k);
         if (w_pos >= (SW+1)'(N)) begin
            w_pos = w_pos - (SW+1)'(N);
         end
         if (i_vec[w_pos[SW-1:0]]) begin
            o_idx = w_pos[SW-1:0];
         end
      end
   end

endmodule

// File: rtl/fire_scheduler.sv
// Chooses one excited transition per firing (round-robin or LFSR-seeded),
// spaces firings so excitation can settle, and flags deadlock.
module fire_scheduler
   import sched_pkg::*;
#(
   parameter int                N           = 8,
   parameter int                FW          = idx_w(N),
   parameter int                LFSR_W      = 16,
   parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
   parameter int                STALL_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          random_mode,
   input  logic          single_step,
   input  logic          step,
   input  logic [N-1:0]  excited,
   output logic [FW-1:0] fire,
   output logic          fire_valid,
   output logic          deadlock,
   output logic [31:0]   fire_count
);

   localparam int                SW        = (N > 1) ? $clog2(N) : 1;
   localparam int                SCW       = $clog2(STALL_LIMIT + 1);
   localparam logic [FW-1:0]     IDLE_CODE = FW'(fire_idle(N));
   localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W));
   localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic [LFSR_W-1:0] r_lfsr;
   logic [SW-1:0]     r_last;
   logic [SCW-1:0]    r_stall;
   logic [FW-1:0]     r_fire;
   logic              r_fire_valid;
   logic              r_deadlock;
   logic [31:0]       r_count;

   logic [SW-1:0]     w_rr_start;
   logic [SW:0]       w_rnd_ext;
   logic [SW-1:0]     w_rnd_start;
   logic [SW-1:0]     w_start;
   logic [SW-1:0]     w_pick_idx;
   logic              w_pick_any;
   logic              w_stall_hit;
   logic              w_enter_fire;

   // Free-running LFSR so the random start depends only on time since reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= SEED_EFF;
      end else begin
         r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
      end
   end

   assign w_rr_start  = (r_last == SW'(N - 1)) ? '0 : r_last + 1'b1;
   assign w_rnd_ext   = {1'b0, r_lfsr[SW-1:0]};
   assign w_rnd_start = (w_rnd_ext >= (SW+1)'(N)) ? SW'(w_rnd_ext - (SW+1)'(N))
                                                  : r_lfsr[SW-1:0];
   assign w_start     = random_mode ? w_rnd_start : w_rr_start;

   wrap_priority_pick #(
      .N  (N),
      .SW (SW)
   ) u_pick (
      .i_vec   (excited),
      .i_start (w_start),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_stall_hit  = (r_stall == SCW'(STALL_LIMIT - 1));
   assign w_enter_fire = (w_next == S_FIRE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Dropping run overrides every other transition, including step.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_next = S_PICK;
         S_PICK: begin
            if (w_pick_any) begin
               w_next = S_FIRE;
            end else if (w_stall_hit) begin
               w_next = S_DEAD;
            end
         end
         S_FIRE:   w_next = S_SETTLE;
         S_SETTLE: w_next = single_step ? S_HOLD : S_PICK;
         S_HOLD:   if (step) w_next = S_PICK;
         S_DEAD:   w_next = S_DEAD;
         default:  w_next = S_IDLE;
      endcase
      if (!run) begin
         w_next = S_IDLE;
      end
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fire       <= IDLE_CODE;
         r_fire_valid <= 1'b0;
         r_deadlock   <= 1'b0;
         r_count      <= '0;
         r_last       <= SW'(N - 1);
         r_stall      <= '0;
      end else begin
         r_fire       <= w_enter_fire ? FW'(w_pick_idx) : IDLE_CODE;
         r_fire_valid <= w_enter_fire;
         r_deadlock   <= (w_next == S_DEAD);
         if (w_enter_fire) begin
            r_last <= w_pick_idx;
            if (r_count != '1) begin
               r_count <= r_count + 32'd1;
            end
         end
         if (w_next == S_IDLE || w_enter_fire) begin
            r_stall <= '0;
         end else if (r_state == S_PICK) begin
            r_stall <= r_stall + 1'b1;
         end
      end
   end

   assign fire       = r_fire;
   assign fire_valid = r_fire_valid;
   assign deadlock   = r_deadlock;
   assign fire_count = r_count;

endmodule
